multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mc_pkg.sv | 39 +++
 rtl/mc_wait_timer.sv | 38 +++
 rtl/multicycle_control.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// ============================================================================
// Module      : mc_pkg
// Description : Shared types and constants for the multicycle control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_EXEC_BR  = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WR   = 4'd7,
    ST_WB_R     = 4'd8,
    ST_WB_I     = 4'd9,
    ST_WB_MEM   = 4'd10,
    ST_HALT     = 4'd11
  } state_t;

  localparam logic [3:0] OP_R   = 4'b0000;
  localparam logic [3:0] OP_I   = 4'b0001;
  localparam logic [3:0] OP_BEQ = 4'b0101;
  localparam logic [3:0] OP_BNE = 4'b0110;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;

  localparam logic [2:0] c_aluAdd   = 3'b000;
  localparam logic [2:0] c_aluSub   = 3'b001;
  localparam logic [2:0] c_aluRType = 3'b010;
  localparam logic [2:0] c_aluIType = 3'b011;

endpackage

`default_nettype wire

// File: rtl/mc_wait_timer.sv
// ============================================================================
// Module      : mc_wait_timer
// Description : Counts memory-wait cycles within one state visit and flags
//               expiry on the WAIT_MAX-th waiting cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_waiting,
  input  logic i_clear,
  output logic o_expired
);

  localparam int c_cntW = $clog2(WAIT_MAX + 1);

  logic [c_cntW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_waiting) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Fires combinationally so the FSM can leave for HALT on this same edge.
  assign o_expired = i_waiting && (r_count == c_cntW'(WAIT_MAX - 1));

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module      : multicycle_control
// Description : Multicycle CPU control FSM with Moore-decoded datapath controls.
//               Optional memory-wait timeout enabled by MC_WAIT_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control
  import mc_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int OP_W     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op,
  input  logic            mem_ready,
  output logic            PCWrite,
  output logic            IRWrite,
  output logic            IorD,
  output logic            RegDst,
  output logic            ALUSrc,
  output logic            MemtoReg,
  output logic            RegWrite,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            Branch,
  output logic            Branch_not,
  output logic [2:0]      ALUop,
  output logic            instr_done,
  output logic            mem_err
);

  state_t r_state;
  state_t w_nextState;
  logic   w_timeout;

  logic w_isR, w_isI, w_isBeq, w_isBne, w_isLw, w_isSw;
  assign w_isR   = (op == OP_W'(OP_R));
  assign w_isI   = (op == OP_W'(OP_I));
  assign w_isBeq = (op == OP_W'(OP_BEQ));
  assign w_isBne = (op == OP_W'(OP_BNE));
  assign w_isLw  = (op == OP_W'(OP_LW));
  assign w_isSw  = (op == OP_W'(OP_SW));

`ifdef MC_WAIT_TIMEOUT_EN
  logic w_waiting;
  logic w_stateExit;
  logic r_memErr;

  assign w_waiting   = ((r_state == ST_FETCH) || (r_state == ST_MEM_RD) ||
                        (r_state == ST_MEM_WR)) && !mem_ready;
  assign w_stateExit = (w_nextState != r_state);

  mc_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_waitTimer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_waiting (w_waiting),
    .i_clear   (w_stateExit),
    .o_expired (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_memErr <= 1'b0;
    end else if (w_timeout) begin
      r_memErr <= 1'b1;
    end
  end

  assign mem_err = r_memErr & rst_n;
`else
  assign w_timeout = 1'b0;
  assign mem_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_FETCH:    if (mem_ready) w_nextState = ST_DECODE;
      ST_DECODE: begin
        if (w_isR)                   w_nextState = ST_EXEC_R;
        else if (w_isI)              w_nextState = ST_EXEC_I;
        else if (w_isBeq || w_isBne) w_nextState = ST_EXEC_BR;
        else if (w_isLw || w_isSw)   w_nextState = ST_MEM_ADDR;
        else                         w_nextState = ST_HALT;
      end
      ST_EXEC_R:   w_nextState = ST_WB_R;
      ST_EXEC_I:   w_nextState = ST_WB_I;
      ST_EXEC_BR:  w_nextState = ST_FETCH;
      ST_MEM_ADDR: begin
        if (w_isLw)      w_nextState = ST_MEM_RD;
        else if (w_isSw) w_nextState = ST_MEM_WR;
        else             w_nextState = ST_HALT;
      end
      ST_MEM_RD:   if (mem_ready) w_nextState = ST_WB_MEM;
      ST_MEM_WR:   if (mem_ready) w_nextState = ST_FETCH;
      ST_WB_R, ST_WB_I, ST_WB_MEM: w_nextState = ST_FETCH;
      ST_HALT:     w_nextState = ST_HALT;
      default:     w_nextState = ST_HALT;
    endcase
    if (w_timeout) w_nextState = ST_HALT;
  end

  // Outputs are held at zero for as long as reset is asserted.
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    IorD       = 1'b0;
    RegDst     = 1'b0;
    ALUSrc     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Branch     = 1'b0;
    Branch_not = 1'b0;
    ALUop      = c_aluAdd;
    instr_done = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_FETCH: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          PCWrite = mem_ready;
        end
        ST_EXEC_R:  ALUop = c_aluRType;
        ST_EXEC_I: begin
          ALUop  = c_aluIType;
          ALUSrc = 1'b1;
        end
        ST_EXEC_BR: begin
          ALUop      = c_aluSub;
          Branch     = w_isBeq;
          Branch_not = w_isBne;
          instr_done = 1'b1;
        end
        ST_MEM_ADDR: ALUSrc = 1'b1;
        ST_MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        ST_MEM_WR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        ST_WB_R: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        ST_WB_I: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        ST_WB_MEM: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control against a route-table
//               instruction model; honours MC_WAIT_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  localparam int WAIT_MAX = 15;
`ifdef MC_WAIT_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  // {PCWrite,IRWrite,IorD,RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Branch_not,ALUop,instr_done}
  localparam logic [14:0] V_ZERO       = 15'b0;
  localparam logic [14:0] V_FETCH_RDY  = 15'b1_1_0_0_0_0_0_1_0_0_0_000_0;
  localparam logic [14:0] V_FETCH_WAIT = 15'b0_1_0_0_0_0_0_1_0_0_0_000_0;
  localparam logic [14:0] V_EXEC_R     = 15'b0_0_0_0_0_0_0_0_0_0_0_010_0;
  localparam logic [14:0] V_WB_R       = 15'b0_0_0_1_0_0_1_0_0_0_0_000_1;
  localparam logic [14:0] V_BNE        = 15'b0_0_0_0_0_0_0_0_0_0_1_001_1;
  localparam logic [14:0] V_MADDR      = 15'b0_0_0_0_1_0_0_0_0_0_0_000_0;
  localparam logic [14:0] V_MRD        = 15'b0_0_1_0_0_0_0_1_0_0_0_000_0;
  localparam logic [14:0] V_WBMEM      = 15'b0_0_0_0_0_1_1_0_0_0_0_000_1;
  localparam logic [14:0] V_MWR        = 15'b0_0_1_0_0_0_0_0_1_0_0_000_0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_ready = 1'b0;
  logic [3:0] op = 4'b0;
  logic PCWrite, IRWrite, IorD, RegDst, ALUSrc, MemtoReg, RegWrite;
  logic MemRead, MemWrite, Branch, Branch_not, instr_done, mem_err;
  logic [2:0] ALUop;

  multicycle_control #(.WAIT_MAX(WAIT_MAX), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .RegDst(RegDst),
    .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
    .Branch_not(Branch_not), .ALUop(ALUop), .instr_done(instr_done),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  logic [14:0] dutVec;
  assign dutVec = {PCWrite, IRWrite, IorD, RegDst, ALUSrc, MemtoReg, RegWrite,
                   MemRead, MemWrite, Branch, Branch_not, ALUop, instr_done};

  int nTests = 0;
  int nFail  = 0;

  // Model: an instruction is a route of named steps; memory steps stall.
  string      mStep = "F";
  int         mIdx  = 0;
  logic [3:0] mOp   = 4'b0;
  int         mWait = 0;
  bit         mErr  = 1'b0;
  logic [14:0] snapVec;
  logic        snapErr;

  function automatic string stepAt(logic [3:0] o, int i);
    if (i == 0) return "F";
    if (i == 1) return "D";
    case (o)
      4'b0000: return (i == 2) ? "XR" : (i == 3) ? "WR" : "";
      4'b0001: return (i == 2) ? "XI" : (i == 3) ? "WI" : "";
      4'b0101, 4'b0110: return (i == 2) ? "XB" : "";
      4'b1000: return (i == 2) ? "MA" : (i == 3) ? "MR" : (i == 4) ? "WM" : "";
      4'b1001: return (i == 2) ? "MA" : (i == 3) ? "MW" : "";
      default: return (i == 2) ? "H" : "";
    endcase
  endfunction

  function automatic logic [14:0] expOut(string s, logic [3:0] o, logic mr);
    logic pcw, irw, iord, rdst, asrc, m2r, rw, mrd, mwr, br, brn, done;
    logic [2:0] aop;
    {pcw, irw, iord, rdst, asrc, m2r, rw, mrd, mwr, br, brn, done} = '0;
    aop = 3'd0;
    if (s == "F")  begin pcw = mr; irw = 1; mrd = 1; end
    if (s == "XR") aop = 3'd2;
    if (s == "XI") begin aop = 3'd3; asrc = 1; end
    if (s == "XB") begin aop = 3'd1; br = (o == 4'b0101); brn = (o == 4'b0110); done = 1; end
    if (s == "MA") asrc = 1;
    if (s == "MR") begin mrd = 1; iord = 1; end
    if (s == "MW") begin mwr = 1; iord = 1; done = mr; end
    if (s == "WR") begin rdst = 1; rw = 1; done = 1; end
    if (s == "WI") begin rw = 1; done = 1; end
    if (s == "WM") begin m2r = 1; rw = 1; done = 1; end
    return {pcw, irw, iord, rdst, asrc, m2r, rw, mrd, mwr, br, brn, aop, done};
  endfunction

  task automatic advance(input logic rn, input logic mr, input logic [3:0] o);
    string nxt;
    if (!rn) begin
      mStep = "F"; mIdx = 0; mWait = 0; mErr = 1'b0;
    end else if (mStep == "H") begin
      mStep = "H";
    end else if ((mStep == "F" || mStep == "MR" || mStep == "MW") && !mr) begin
      mWait++;
      if (TMO && mWait == WAIT_MAX) begin
        mStep = "H"; mErr = 1'b1; mWait = 0;
      end
    end else begin
      if (mStep == "D") mOp = o;
      mIdx++;
      nxt = stepAt(mOp, mIdx);
      if (nxt == "") begin mIdx = 0; nxt = "F"; end
      mStep = nxt;
      mWait = 0;
    end
  endtask

  task automatic tick(input logic rn, input logic mr, input logic [3:0] o);
    logic [14:0] ev;
    logic        ee;
    @(negedge clk);
    rst_n = rn; mem_ready = mr; op = o;
    #1;
    ev = rn ? expOut(mStep, mOp, mr) : V_ZERO;
    ee = rn ? mErr : 1'b0;
    snapVec = dutVec;
    snapErr = mem_err;
    nTests++;
    if (dutVec !== ev) begin
      nFail++;
      $display("FAIL ctl step=%s op=%b mr=%b: got %b want %b", mStep, mOp, mr, dutVec, ev);
    end
    nTests++;
    if (mem_err !== ee) begin
      nFail++;
      $display("FAIL mem_err step=%s: got %b want %b", mStep, mem_err, ee);
    end
    nTests++;
    if (RegWrite && MemWrite) begin
      nFail++;
      $display("FAIL regwrite_memwrite_overlap: got 11 want not both");
    end
    @(posedge clk);
    advance(rn, mr, o);
  endtask

  task automatic lit(input string name, input logic [14:0] want);
    nTests++;
    if (snapVec !== want) begin
      nFail++;
      $display("FAIL %s: got %b want %b", name, snapVec, want);
    end
  endtask

  task automatic litErr(input string name, input logic want);
    nTests++;
    if (snapErr !== want) begin
      nFail++;
      $display("FAIL %s: got %b want %b", name, snapErr, want);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       rn, mr;
    logic [3:0] o;
    int         hc;

    tick(1'b0, 1'b1, 4'b0000);  lit("reset_outputs", V_ZERO); litErr("reset_mem_err", 1'b0);

    // R-type, 4 cycles
    tick(1'b1, 1'b1, 4'b0000);  lit("r_fetch", V_FETCH_RDY);
    tick(1'b1, 1'b1, 4'b0000);  lit("r_decode", V_ZERO);
    tick(1'b1, 1'b1, 4'b0000);  lit("r_exec", V_EXEC_R);
    tick(1'b1, 1'b1, 4'b0000);  lit("r_wb", V_WB_R);

    // BNE, 3 cycles
    tick(1'b1, 1'b1, 4'b0110);  lit("bne_fetch", V_FETCH_RDY);
    tick(1'b1, 1'b1, 4'b0110);  lit("bne_decode", V_ZERO);
    tick(1'b1, 1'b1, 4'b0110);  lit("bne_exec", V_BNE);

    // LW with 3 wait cycles in MEM_RD
    tick(1'b1, 1'b1, 4'b1000);  lit("lw_fetch", V_FETCH_RDY);
    tick(1'b1, 1'b1, 4'b1000);
    tick(1'b1, 1'b1, 4'b1000);  lit("lw_maddr", V_MADDR);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 4'b1000); lit("lw_mrd_wait", V_MRD);
    end
    tick(1'b1, 1'b1, 4'b1000);  lit("lw_mrd_done", V_MRD);
    tick(1'b1, 1'b1, 4'b1000);  lit("lw_wbmem", V_WBMEM);

    // Illegal opcode halts until reset
    tick(1'b1, 1'b1, 4'b1111);  lit("halt_fetch", V_FETCH_RDY);
    tick(1'b1, 1'b1, 4'b1111);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1, 4'b1111); lit("halt_zero", V_ZERO);
    end
    tick(1'b0, 1'b1, 4'b0000);
    tick(1'b1, 1'b1, 4'b0000);  lit("halt_reset_fetch", V_FETCH_RDY);
    tick(1'b1, 1'b1, 4'b0000);
    tick(1'b1, 1'b1, 4'b0000);
    tick(1'b1, 1'b1, 4'b0000);

    // SW aborted by reset while waiting in MEM_WR
    tick(1'b1, 1'b1, 4'b1001);
    tick(1'b1, 1'b1, 4'b1001);
    tick(1'b1, 1'b1, 4'b1001);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 4'b1001); lit("sw_mwr_wait", V_MWR);
    end
    tick(1'b0, 1'b0, 4'b1001);  lit("sw_reset_drop", V_ZERO);
    tick(1'b1, 1'b0, 4'b1001);  lit("sw_after_reset_fetch", V_FETCH_WAIT);

    // FETCH starved of mem_ready
    tick(1'b0, 1'b0, 4'b0000);
    for (int i = 0; i < 100; i++) begin
      tick(1'b1, 1'b0, 4'b0000);
      if (TMO && i == WAIT_MAX - 1) begin lit("tmo_last_wait", V_FETCH_WAIT); litErr("tmo_err_low", 1'b0); end
      if (TMO && i == WAIT_MAX)     begin lit("tmo_halt", V_ZERO); litErr("tmo_err_set", 1'b1); end
    end
    if (TMO) begin lit("tmo_still_halt", V_ZERO); litErr("tmo_err_sticky", 1'b1); end
    else begin lit("notmo_still_fetch", V_FETCH_WAIT); litErr("notmo_err_zero", 1'b0); end
    tick(1'b0, 1'b0, 4'b0000);  litErr("reset_clears_err", 1'b0);

    // Randomized traffic
    hc = 0;
    for (int c = 0; c < 2000; c++) begin
      o = op;
      if (mStep == "F") begin
        case ($urandom_range(0, 12))
          0, 1:   o = 4'b0000;
          2, 3:   o = 4'b0001;
          4, 5:   o = 4'b0101;
          6, 7:   o = 4'b0110;
          8, 9:   o = 4'b1000;
          10, 11: o = 4'b1001;
          default: o = ($urandom_range(0, 1) == 1) ? 4'b1111 : 4'b0011;
        endcase
      end
      if (mStep == "H") hc++; else hc = 0;
      rn = !(($urandom_range(0, 49) == 0) || (hc > 4));
      mr = ($urandom_range(0, 9) < 7);
      tick(rn, mr, o);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

`default_nettype wire
